// File: rtl/pipe_adder_128.sv
// rtl/pipe_adder_128.sv - pipelined handshaked adder, one slice per stage; PIPE_ADDER_OVF_EN adds signed overflow
module pipe_adder_128 #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage k holds sum slices 0..k resolved, the carry out of slice k, and the operands
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];

  // What each stage would load: the input port for stage 0, the previous stage otherwise
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];

  logic [STAGES-1:0] ready;

  // Ready chains back from out_ready: a stage can load if empty or if it empties this cycle
  always_comb begin : handshake_comb
    logic r;
    r     = out_ready;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r        = !valid_q[k] || r;
      ready[k] = r;
    end
  end

  assign in_ready = ready[0];

  // Select each stage's upstream source
  always_comb begin
    src_valid    = '0;
    src_carry    = '0;
    src_valid[0] = in_valid;
    src_carry[0] = carry_in;
    src_sum[0]   = '0;
    src_a[0]     = a;
    src_b[0]     = b;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
    end
  end

  // Resolve slice k on entry to stage k; stalled stages keep their contents
  always_comb begin : stage_comb
    logic [SW:0] slice;
    slice   = '0;
    valid_d = valid_q;
    carry_d = carry_q;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = sum_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = src_valid[k];
        // Data only moves with a valid op, so bubbles leave the registers quiet
        if (src_valid[k]) begin
          slice = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
                + {{SW{1'b0}}, src_carry[k]};
          sum_d[k]               = src_sum[k];
          sum_d[k][k*SW +: SW]   = slice[SW-1:0];
          carry_d[k]             = slice[SW];
          a_d[k]                 = src_a[k];
          b_d[k]                 = src_b[k];
        end
      end
    end
  end

  // Pipeline registers, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign carry_out = carry_q[LAST];

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow is decided when the top slice lands, using operand MSBs from the skew buffer
  always_comb begin
    ovf_d = ovf_q;
    if (ready[LAST] && src_valid[LAST]) begin
      ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
              (sum_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    end
  end

  // Overflow register travels with the final stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder_128.sv
// tb/tb_pipe_adder_128.sv - self-checking bench for pipe_adder_128 with a queue-based reference model
module tb_pipe_adder_128;
  localparam int WIDTH  = 128;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef PIPE_ADDER_OVF_EN
  logic             overflow;
`endif

  pipe_adder_128 #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int               e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   edge_cnt   = 0;
  bit   strict_lat = 1'b0;

  function automatic exp_t model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                 input logic c_i, input int e_i);
    exp_t r;
    logic [WIDTH:0] full;
    full = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
    r.s  = full[WIDTH-1:0];
    r.c  = full[WIDTH];
    r.o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (r.s[WIDTH-1] != a_i[WIDTH-1]);
    r.e  = e_i;
    return r;
  endfunction

  task automatic check_w(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: score the transfers about to happen, take the edge, settle past it
  task automatic cycle();
    bit   acc;
    bit   oxf;
    exp_t ex;
    int   lat;
    #1;
    acc = in_valid && in_ready;
    oxf = out_valid && out_ready;
    if (oxf) begin
      if (exp_q.size() == 0) begin
        check_i("out_with_empty_model", exp_q.size(), 1);
      end else begin
        ex = exp_q.pop_front();
        check_w("sum", sum, ex.s);
        check_b("carry_out", carry_out, ex.c);
`ifdef PIPE_ADDER_OVF_EN
        check_b("overflow", overflow, ex.o);
`endif
        lat = edge_cnt + 1 - ex.e;
        if (strict_lat) check_i("latency", lat, STAGES);
        else            check_b("latency_min", lat >= STAGES, 1'b1);
      end
    end
    if (acc) exp_q.push_back(model(a, b, carry_in, edge_cnt + 1));
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n         = budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n > 0) begin
      cycle();
      n--;
    end
    check_i("drain_empty", exp_q.size(), 0);
    check_b("drain_out_valid", out_valid, 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    bit               have_hold;
    int               n_acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_w("rst_sum", sum, '0);
    check_b("rst_carry_out", carry_out, 1'b0);
`ifdef PIPE_ADDER_OVF_EN
    check_b("rst_overflow", overflow, 1'b0);
`endif
    rst_n = 1'b1;
    #1;
    check_b("rst_in_ready", in_ready, 1'b1);

    // Full carry ripple, with the latency observed edge by edge
    strict_lat = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    a          = '1;
    b          = '0;
    carry_in   = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_b("ripple_valid_e1", out_valid, 1'b0);
    cycle();
    check_b("ripple_valid_e2", out_valid, 1'b0);
    cycle();
    check_b("ripple_valid_e3", out_valid, 1'b0);
    cycle();
    check_b("ripple_valid_e4", out_valid, 1'b1);
    check_w("ripple_sum", sum, '0);
    check_b("ripple_carry", carry_out, 1'b1);
    drain(20);

    // Streaming back-to-back
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a        = WIDTH'(i);
      b        = WIDTH'(3 * i);
      carry_in = i[0];
      cycle();
    end
    drain(20);

    // Backpressure: fill, hold, then drain one per cycle
    strict_lat = 1'b0;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    n_acc      = 0;
    have_hold  = 1'b0;
    held_s     = '0;
    held_c     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a        = rnd128();
      b        = rnd128();
      carry_in = 1'($urandom());
      #1;
      if (in_ready) n_acc++;
      cycle();
      if (out_valid) begin
        if (have_hold) begin
          check_w("hold_sum", sum, held_s);
          check_b("hold_carry", carry_out, held_c);
        end
        held_s    = sum;
        held_c    = carry_out;
        have_hold = 1'b1;
      end
    end
    check_i("bp_accepted", n_acc, STAGES);
    check_b("bp_in_ready_low", in_ready, 1'b0);
    check_b("bp_out_valid", out_valid, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_b("bubble_free_in_ready", in_ready, 1'b1);
    for (int i = 0; i < STAGES; i++) begin
      check_b("bp_drain_valid", out_valid, 1'b1);
      cycle();
    end
    check_i("bp_drained", exp_q.size(), 0);

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow in both directions
    in_valid = 1'b1;
    a        = {1'b0, {(WIDTH-1){1'b1}}};
    b        = WIDTH'(1);
    carry_in = 1'b0;
    cycle();
    a = {1'b1, {(WIDTH-1){1'b0}}};
    b = {1'b1, {(WIDTH-1){1'b0}}};
    cycle();
    drain(20);
`endif

    // Reset mid-flight: result at the output is discarded along with the rest
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = rnd128() | WIDTH'(1);
      b        = rnd128();
      carry_in = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check_b("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_b("mid_rst_out_valid", out_valid, 1'b0);
    check_w("mid_rst_sum", sum, '0);
    check_b("mid_rst_carry", carry_out, 1'b0);
    exp_q.delete();
    @(posedge clk);
    edge_cnt++;
    #1;
    rst_n = 1'b1;
    #1;
    check_b("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_b("post_rst_no_valid", out_valid, 1'b0);
    end
    in_valid = 1'b1;
    a        = rnd128();
    b        = rnd128();
    carry_in = 1'b1;
    cycle();
    drain(20);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a         = rnd128();
      b         = rnd128();
      carry_in  = 1'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        a = '1;
        b = '0;
      end
      cycle();
    end
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
